// File: rtl/requant_pkg.sv
// Shared widths and int8 limits for the MAC-result requantizer.
package requant_pkg;
    localparam int ACC_W   = 32;
    localparam int MULT_W  = 16;
    localparam int FRAC_W  = 15;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int Q_MAX   = 127;
    localparam int Q_MIN   = -128;
    // Exact signed product of a signed accumulator and a zero-extended unsigned multiplier.
    localparam int PROD_W  = ACC_W + MULT_W + 1;
endpackage

// File: rtl/requant_round_sat.sv
// Combinational requant core: S2 round-half-up shift and S3 zero-point add + clamp.
// Build option REQUANT_RELU_EN raises the lower clamp to the zero point (fused ReLU).
module requant_round_sat #(
    parameter int P_W    = requant_pkg::PROD_W,
    parameter int FRAC_W = requant_pkg::FRAC_W,
    parameter int OUT_W  = requant_pkg::OUT_W
) (
    input  logic signed [P_W-1:0]                   prod,
    input  logic        [requant_pkg::SHIFT_W-1:0]  shift,
    input  logic signed [P_W-1:0]                   r_in,
    input  logic signed [OUT_W-1:0]                 zp,
    output logic signed [P_W-1:0]                   r_out,
    output logic signed [OUT_W-1:0]                 q,
    output logic                                    sat
);
    import requant_pkg::*;

    localparam int S_W = P_W + 1;

    logic        [6:0]     t;
    logic signed [S_W-1:0] half;
    logic signed [S_W-1:0] biased;
    logic signed [S_W-1:0] s;
    logic signed [S_W-1:0] hi;
    logic signed [S_W-1:0] lo;

    // One guard bit above the product keeps prod + 2^(T-1) from wrapping.
    always_comb begin
        t      = 7'(FRAC_W) + 7'(shift);
        half   = S_W'(1) << (t - 7'd1);
        biased = S_W'(prod) + half;
        r_out  = P_W'(biased >>> t);
    end

    // Clamp is decided on the full-width sum so large r never aliases into range.
    always_comb begin
        s  = S_W'(r_in) + S_W'(zp);
        hi = S_W'(Q_MAX);
`ifdef REQUANT_RELU_EN
        lo = (zp > OUT_W'(Q_MIN)) ? S_W'(zp) : S_W'(Q_MIN);
`else
        lo = S_W'(Q_MIN);
`endif
        q   = OUT_W'(s);
        sat = 1'b0;
        if (s > hi) begin
            q   = OUT_W'(Q_MAX);
            sat = 1'b1;
        end else if (s < lo) begin
            q   = OUT_W'(lo);
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/mac_requantizer.sv
// 3-stage int32 -> int8 requantizer on the MAC result strobe, valid/ready on the output.
// REQUANT_RELU_EN (see requant_round_sat) selects the fused-ReLU lower clamp.
module mac_requantizer #(
    parameter int ACC_W  = requant_pkg::ACC_W,
    parameter int MULT_W = requant_pkg::MULT_W,
    parameter int FRAC_W = requant_pkg::FRAC_W,
    parameter int OUT_W  = requant_pkg::OUT_W
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   acc_valid_i,
    input  logic signed [ACC_W-1:0]                acc_data_i,
    output logic                                   acc_ready_o,
    input  logic        [MULT_W-1:0]               mult_i,
    input  logic        [requant_pkg::SHIFT_W-1:0] shift_i,
    input  logic signed [OUT_W-1:0]                zero_point_i,
    output logic                                   q_valid_o,
    output logic signed [OUT_W-1:0]                q_data_o,
    output logic                                   q_sat_o,
    input  logic                                   q_ready_i,
    output logic                                   ovf_o,
    input  logic                                   ovf_clr_i
);
    import requant_pkg::*;

    localparam int P_W    = ACC_W + MULT_W + 1;
    localparam int STAGES = 3;

    logic [STAGES:1]        vld_pipe;
    logic                   adv;
    logic                   accept;

    logic signed [P_W-1:0]  acc_ext;
    logic signed [P_W-1:0]  mult_ext;
    logic signed [P_W-1:0]  prod;
    logic signed [P_W-1:0]  s1_prod;
    logic [SHIFT_W-1:0]     s1_shift;
    logic signed [OUT_W-1:0] s1_zp;
    logic signed [P_W-1:0]  s2_r;
    logic signed [OUT_W-1:0] s2_zp;
    logic signed [P_W-1:0]  rs_r;
    logic signed [OUT_W-1:0] rs_q;
    logic                   rs_sat;

    // Whole pipe stalls together; a full pipe with a blocked output cannot accept.
    assign q_valid_o   = vld_pipe[STAGES];
    assign adv         = !q_valid_o || q_ready_i;
    assign acc_ready_o = adv;
    assign accept      = acc_valid_i && adv;

    assign acc_ext  = P_W'(acc_data_i);
    assign mult_ext = P_W'({1'b0, mult_i});
    assign prod     = acc_ext * mult_ext;

    requant_round_sat #(
        .P_W    (P_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .prod  (s1_prod),
        .shift (s1_shift),
        .r_in  (s2_r),
        .zp    (s2_zp),
        .r_out (rs_r),
        .q     (rs_q),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_pipe <= '0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s2_r     <= '0;
            s2_zp    <= '0;
            q_data_o <= '0;
            q_sat_o  <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            s1_prod  <= prod;
            s1_shift <= shift_i;
            s1_zp    <= zero_point_i;
            s2_r     <= rs_r;
            s2_zp    <= s1_zp;
            q_data_o <= rs_q;
            q_sat_o  <= rs_sat;
        end
    end

    // A strobe with no room is lost for good; set beats clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                      ovf_o <= 1'b0;
        else if (acc_valid_i && !adv)     ovf_o <= 1'b1;
        else if (ovf_clr_i)               ovf_o <= 1'b0;
    end
endmodule
